// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - instruction FIFO and T0..T3 timestep sequencer (optional RETIRE_CNT_EN retire counter)
module instruction_sequencer #(
    parameter int DEPTH = 4,
    parameter int W     = 10,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  Data,
    input  logic          Push,
    input  logic          Halt,
    input  logic          Clr,
    output logic [W-1:0]  INST,
    output logic [1:0]    T,
    output logic          Busy,
    output logic          Done,
    output logic          Full,
    output logic          Empty,
    output logic [CW-1:0] Count,
    output logic          Ovf,
    output logic          Err
`ifdef RETIRE_CNT_EN
    ,output logic [15:0]  Retired
`endif
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d, empty_q, empty_d;
    logic [0:0]    state_q, state_d;
    logic [1:0]    t_q, t_d;
    logic [W-1:0]  inst_q, inst_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;
    logic          err_q, err_d;
    logic          pop, push_acc, can_fetch, retire;
    logic [W-1:0]  head;

    assign head      = mem_q[rd_q];
    assign can_fetch = !empty_q && !Halt;

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        inst_d  = inst_q;
        done_d  = 1'b0;
        err_d   = err_q;
        pop     = 1'b0;
        retire  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (can_fetch) begin
                    state_d = ST_RUN;
                    inst_d  = head;
                    pop     = 1'b1;
                    t_d     = 2'd0;
                end
            end
            ST_RUN: begin
                // Clr is meaningless at T0; T3 always retires so T never wraps on its own
                retire = (t_q == 2'd3) || ((t_q != 2'd0) && Clr);
                if (retire) begin
                    done_d = 1'b1;
                    t_d    = 2'd0;
                    if ((t_q == 2'd3) && !Clr) begin
                        err_d = 1'b1;
                    end
                    if (can_fetch) begin
                        inst_d = head;
                        pop    = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    t_d = t_q + 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                t_d     = 2'd0;
            end
        endcase
    end

    // A pop on the same edge frees the slot a push into a full FIFO needs
    always_comb begin
        push_acc = Push && (!full_q || pop);
        ovf_d    = ovf_q | (Push && full_q && !pop);
        count_d  = count_q + {{(CW-1){1'b0}}, push_acc} - {{(CW-1){1'b0}}, pop};
        full_d   = (count_d == CW'(DEPTH));
        empty_d  = (count_d == '0);
        wr_d     = push_acc ? wr_q + AW'(1) : wr_q;
        rd_d     = pop ? rd_q + AW'(1) : rd_q;
    end

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wr_q] <= Data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            state_q <= ST_IDLE;
            t_q     <= 2'd0;
            inst_q  <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            state_q <= state_d;
            t_q     <= t_d;
            inst_q  <= inst_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

`ifdef RETIRE_CNT_EN
    logic [15:0] retired_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= 16'd0;
        end else if (done_d) begin
            retired_q <= retired_q + 16'd1;
        end
    end

    assign Retired = retired_q;
`endif

    assign INST  = inst_q;
    assign T     = t_q;
    assign Busy  = (state_q == ST_RUN);
    assign Done  = done_q;
    assign Full  = full_q;
    assign Empty = empty_q;
    assign Count = count_q;
    assign Ovf   = ovf_q;
    assign Err   = err_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb/tb_instruction_sequencer.sv - directed self-checking bench for instruction_sequencer
module tb_instruction_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] Data;
    logic       Push, Halt, Clr;
    logic [9:0] INST;
    logic [1:0] T;
    logic       Busy, Done, Full, Empty, Ovf, Err;
    logic [2:0] Count;
`ifdef RETIRE_CNT_EN
    logic [15:0] Retired;
`endif

    int vectors = 0;
    int miscompares = 0;

    instruction_sequencer #(.DEPTH(4), .W(10)) dut (
        .clk(clk), .rst_n(rst_n), .Data(Data), .Push(Push), .Halt(Halt), .Clr(Clr),
        .INST(INST), .T(T), .Busy(Busy), .Done(Done), .Full(Full), .Empty(Empty),
        .Count(Count), .Ovf(Ovf), .Err(Err)
`ifdef RETIRE_CNT_EN
        , .Retired(Retired)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; Data = '0; Push = 1'b0; Halt = 1'b0; Clr = 1'b0;
        tick(); tick();
        chk("rst_inst", INST, 0);   chk("rst_t", T, 0);       chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);   chk("rst_empty", Empty, 1); chk("rst_full", Full, 0);
        chk("rst_count", Count, 0); chk("rst_ovf", Ovf, 0);   chk("rst_err", Err, 0);
        rst_n = 1'b1;
        tick();

        // single 2-step instruction, Clr at T1
        Data = 10'h040; Push = 1'b1;
        tick();
        chk("t1_count_after_push", Count, 1); chk("t1_busy_before_fetch", Busy, 0);
        Push = 1'b0;
        tick();
        chk("t1_inst", INST, 10'h040); chk("t1_t0", T, 0); chk("t1_busy", Busy, 1); chk("t1_empty", Empty, 1);
        tick();
        chk("t1_t1", T, 1);
        Clr = 1'b1;
        tick();
        chk("t1_done", Done, 1); chk("t1_t_ret", T, 0); chk("t1_busy_ret", Busy, 0); chk("t1_empty_ret", Empty, 1);
        Clr = 1'b0;
        tick();
        chk("t1_done_pulse", Done, 0);

        // back-to-back 4-step instructions
        Data = 10'h012; Push = 1'b1;
        tick();
        Data = 10'h303;
        tick();
        chk("t2_inst_a", INST, 10'h012); chk("t2_count_pushpop", Count, 1);
        Push = 1'b0;
        tick(); chk("t2_a_t1", T, 1);
        tick(); chk("t2_a_t2", T, 2); chk("t2_a_nodone", Done, 0);
        tick(); chk("t2_a_t3", T, 3);
        Clr = 1'b1;
        tick();
        chk("t2_a_done", Done, 1); chk("t2_inst_b", INST, 10'h303); chk("t2_b_t0", T, 0);
        chk("t2_b_busy", Busy, 1); chk("t2_b_count", Count, 0);
        Clr = 1'b0;
        tick(); chk("t2_b_t1", T, 1); chk("t2_b_nodone1", Done, 0);
        tick(); chk("t2_b_nodone2", Done, 0);
        tick(); chk("t2_b_t3", T, 3); chk("t2_b_nodone3", Done, 0);
        Clr = 1'b1;
        tick();
        chk("t2_b_done", Done, 1); chk("t2_b_idle", Busy, 0); chk("t2_err", Err, 0);
        Clr = 1'b0;

        // overflow under Halt, then FIFO-order drain
        Halt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            Data = 10'h101 + 10'(i); Push = 1'b1;
            tick();
        end
        Push = 1'b0;
        chk("t3_full", Full, 1); chk("t3_count", Count, 4); chk("t3_ovf", Ovf, 1);
        chk("t3_nofetch", Busy, 0); chk("t3_empty", Empty, 0);
        tick();
        chk("t3_halt_holds", Busy, 0);
        Halt = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_inst%0d", i), INST, 10'h101 + 10'(i));
            chk($sformatf("t3_t0_%0d", i), T, 0);
            chk($sformatf("t3_busy%0d", i), Busy, 1);
            tick();
            chk($sformatf("t3_t1_%0d", i), T, 1);
            Clr = 1'b1;
            tick();
            chk($sformatf("t3_done%0d", i), Done, 1);
            Clr = 1'b0;
        end
        chk("t3_idle", Busy, 0); chk("t3_drained", Empty, 1); chk("t3_ovf_sticky", Ovf, 1);

        // timeout: Clr never asserted
        Data = 10'h2AA; Push = 1'b1;
        tick();
        Push = 1'b0;
        tick(); chk("t4_inst", INST, 10'h2AA); chk("t4_t0", T, 0);
        tick(); chk("t4_t1", T, 1);
        tick(); chk("t4_t2", T, 2);
        tick(); chk("t4_t3", T, 3); chk("t4_noerr_yet", Err, 0);
        tick();
        chk("t4_done", Done, 1); chk("t4_err", Err, 1); chk("t4_t_ret", T, 0); chk("t4_busy", Busy, 0);
        tick();
        chk("t4_err_sticky", Err, 1);

        // asynchronous reset mid-instruction with queued words
        Data = 10'h011; Push = 1'b1;
        tick();
        Data = 10'h022;
        tick();
        Data = 10'h033;
        tick();
        Push = 1'b0;
        tick();
        chk("t5_t2", T, 2); chk("t5_count", Count, 2); chk("t5_inst", INST, 10'h011);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_t", T, 0); chk("t5_busy", Busy, 0); chk("t5_count_rst", Count, 0);
        chk("t5_inst_rst", INST, 0); chk("t5_err_rst", Err, 0); chk("t5_ovf_rst", Ovf, 0);
        chk("t5_empty_rst", Empty, 1);
        tick();
        chk("t5_nodone", Done, 0);
        rst_n = 1'b1;
        tick();
        chk("t5_stay_idle", Busy, 0);

`ifdef RETIRE_CNT_EN
        chk("t6_retired_rst", Retired, 0);
        Halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            Data = 10'h040 + 10'(i); Push = 1'b1;
            tick();
        end
        Push = 1'b0; Halt = 1'b0; Clr = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        Clr = 1'b0;
        chk("t6_retired", Retired, 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
